// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared funct3 codes, FSM states and access-check helper for dmem_lsu
package dmem_pkg;

    localparam int WCNT_W = 4;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Alignment and encoding faults; the address range check lives in the top
    function automatic logic access_fault(input logic we, input logic [2:0] f3, input logic [1:0] lo);
        logic f;
        case (f3)
            F3_B:    f = 1'b0;
            F3_H:    f = lo[0];
            F3_W:    f = |lo;
            F3_BU:   f = we;
            F3_HU:   f = we | lo[0];
            default: f = 1'b1;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/dmem_if.sv
// rtl/dmem_if.sv - request/response handshake bundle between core and dmem_lsu
interface dmem_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - store byte-enable/replication and load lane select/extension
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);
    logic [7:0]  sel_b;
    logic [15:0] sel_h;

    // Replicate store data across lanes so the byte enables alone pick the target
    always_comb begin
        be        = 4'b1111;
        wdata_rep = wdata;
        case (funct3)
            F3_B: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            F3_H: begin
                be        = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Pick the addressed byte/half and extend according to funct3
    always_comb begin
        case (addr_lo)
            2'd0:    sel_b = rword[7:0];
            2'd1:    sel_b = rword[15:8];
            2'd2:    sel_b = rword[23:16];
            default: sel_b = rword[31:24];
        endcase
        sel_h = addr_lo[1] ? rword[31:16] : rword[15:0];
        case (funct3)
            F3_B:    rdata_ext = {{24{sel_b[7]}}, sel_b};
            F3_BU:   rdata_ext = {24'd0, sel_b};
            F3_H:    rdata_ext = {{16{sel_h[15]}}, sel_h};
            F3_HU:   rdata_ext = {16'd0, sel_h};
            default: rdata_ext = rword;
        endcase
    end
endmodule

// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - data memory with load/store unit; DMEM_PERF_CNT_EN adds perf counters
module dmem_lsu
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 1
) (
    input  logic   clk,
    input  logic   rst,
    dmem_if.slave  bus
`ifdef DMEM_PERF_CNT_EN
    ,
    output logic [31:0] perf_loads,
    output logic [31:0] perf_stores,
    output logic [31:0] perf_errs
`endif
);
    localparam int IDX_W = $clog2(DEPTH);

    logic [31:0] mem [DEPTH];

    state_t            state;
    logic [WCNT_W-1:0] cnt;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;

    logic              a_we;
    logic [2:0]        a_f3;
    logic [ADDR_W-1:0] a_addr;
    logic [31:0]       a_wdata;
    logic              fault;
    logic              access;
    logic [IDX_W-1:0]  idx;
    logic [3:0]        be;
    logic [31:0]       wdata_rep;
    logic [31:0]       rdata_ext;

    // In IDLE the access (LATENCY=0) and the fault check see the live request; later the latched copy
    always_comb begin
        a_we    = (state == S_IDLE) ? bus.req_we     : we_q;
        a_f3    = (state == S_IDLE) ? bus.req_funct3 : f3_q;
        a_addr  = (state == S_IDLE) ? bus.req_addr   : addr_q;
        a_wdata = (state == S_IDLE) ? bus.req_wdata  : wdata_q;
        idx     = a_addr[IDX_W+1:2];
        fault   = access_fault(a_we, a_f3, a_addr[1:0]) | (|a_addr[ADDR_W-1:IDX_W+2]);
        access  = ((state == S_IDLE) && bus.req_valid && !fault && (LATENCY == 0))
                || ((state == S_WAIT) && (cnt == '0));
    end

    dmem_lane_align u_align (
        .funct3    (a_f3),
        .addr_lo   (a_addr[1:0]),
        .wdata     (a_wdata),
        .rword     (mem[idx]),
        .be        (be),
        .wdata_rep (wdata_rep),
        .rdata_ext (rdata_ext)
    );

    // Byte-lane writes only in the access cycle; the array is not touched by reset
    always_ff @(posedge clk) begin
        if (access && a_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
            end
        end
    end

    // Request/response FSM with registered handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            cnt           <= '0;
            we_q          <= 1'b0;
            f3_q          <= 3'd0;
            addr_q        <= '0;
            wdata_q       <= 32'd0;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= 32'd0;
            bus.rsp_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        we_q          <= bus.req_we;
                        f3_q          <= bus.req_funct3;
                        addr_q        <= bus.req_addr;
                        wdata_q       <= bus.req_wdata;
                        bus.req_ready <= 1'b0;
                        if (fault) begin
                            state         <= S_RESP;
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_err   <= 1'b1;
                            bus.rsp_rdata <= 32'd0;
                        end else if (LATENCY == 0) begin
                            state         <= S_RESP;
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_err   <= 1'b0;
                            bus.rsp_rdata <= bus.req_we ? 32'd0 : rdata_ext;
                        end else begin
                            cnt   <= WCNT_W'(LATENCY - 1);
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == '0) begin
                        state         <= S_RESP;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= 1'b0;
                        bus.rsp_rdata <= we_q ? 32'd0 : rdata_ext;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        state         <= S_IDLE;
                        bus.rsp_valid <= 1'b0;
                        bus.rsp_rdata <= 32'd0;
                        bus.rsp_err   <= 1'b0;
                        bus.req_ready <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef DMEM_PERF_CNT_EN
    // Count completed responses by kind at the RESP->IDLE handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_loads  <= 32'd0;
            perf_stores <= 32'd0;
            perf_errs   <= 32'd0;
        end else if (state == S_RESP && bus.rsp_ready) begin
            if (bus.rsp_err)  perf_errs   <= perf_errs + 32'd1;
            else if (we_q)    perf_stores <= perf_stores + 32'd1;
            else              perf_loads  <= perf_loads + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_dmem_lsu.sv
// tb/tb_dmem_lsu.sv - directed self-checking bench for dmem_lsu (LATENCY=2 and LATENCY=0 instances)
module tb_dmem_lsu;
    import dmem_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_if #(.ADDR_W(32)) bus ();
    dmem_if #(.ADDR_W(32)) bus0 ();

`ifdef DMEM_PERF_CNT_EN
    logic [31:0] pl, ps, pe, pl0, ps0, pe0;
`endif

    dmem_lsu #(.ADDR_W(32), .DEPTH(256), .LATENCY(2)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef DMEM_PERF_CNT_EN
        , .perf_loads (pl), .perf_stores (ps), .perf_errs (pe)
`endif
    );

    dmem_lsu #(.ADDR_W(32), .DEPTH(256), .LATENCY(0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
`ifdef DMEM_PERF_CNT_EN
        , .perf_loads (pl0), .perf_stores (ps0), .perf_errs (pe0)
`endif
    );

    int passed = 0;
    int total  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic txn(input string tag, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err, output int cyc);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.rsp_ready  = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        cyc = 1;
        while (bus.rsp_valid !== 1'b1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "_valid"}, bus.rsp_valid, 1);
        rdata = bus.rsp_rdata;
        err   = bus.rsp_err;
        @(posedge clk); #1;
    endtask

    task automatic xt(input string tag, input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err);
        logic [31:0] r;
        logic        e;
        int          c;
        txn(tag, we, f3, addr, wdata, r, e, c);
        chk({tag, "_rdata"}, r, exp_rdata);
        chk({tag, "_err"}, e, exp_err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] r, r0;
        logic        e, e0;
        int          c;
        bus.req_valid = 0; bus.req_we = 0; bus.req_funct3 = 0; bus.req_addr = 0;
        bus.req_wdata = 0; bus.rsp_ready = 1;
        bus0.req_valid = 0; bus0.req_we = 0; bus0.req_funct3 = 0; bus0.req_addr = 0;
        bus0.req_wdata = 0; bus0.rsp_ready = 1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", bus.req_ready, 1);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 0);
        chk("rst_rsp_err",   bus.rsp_err, 0);
        @(negedge clk);
        rst = 1'b0;

        xt("zero10", 1, F3_W, 32'h10, 32'h0, 32'h0, 0);
        xt("zero20", 1, F3_W, 32'h20, 32'h0, 32'h0, 0);

        txn("sw_dead", 1, F3_W, 32'h10, 32'hDEADBEEF, r, e, c);
        chk("sw_dead_latency", c, 3);
        chk("sw_dead_rdata", r, 32'h0);
        chk("sw_dead_err", e, 0);
        xt("lw_dead", 0, F3_W, 32'h10, 32'h0, 32'hDEADBEEF, 0);

        xt("sb13", 1, F3_B, 32'h13, 32'h00000080, 32'h0, 0);
        xt("lw_after_sb", 0, F3_W, 32'h10, 32'h0, 32'h80ADBEEF, 0);
        xt("lb13",  0, F3_B,  32'h13, 32'h0, 32'hFFFFFF80, 0);
        xt("lbu13", 0, F3_BU, 32'h13, 32'h0, 32'h00000080, 0);
        xt("lh12",  0, F3_H,  32'h12, 32'h0, 32'hFFFF80AD, 0);
        xt("lhu10", 0, F3_HU, 32'h10, 32'h0, 32'h0000BEEF, 0);

        txn("f_lw02", 0, F3_W, 32'h02, 32'h0, r, e, c);
        chk("f_lw02_latency", c, 1);
        chk("f_lw02_rdata", r, 32'h0);
        chk("f_lw02_err", e, 1);
        xt("f_sh11",  1, F3_H,   32'h11,  32'h00001234, 32'h0, 1);
        xt("f_range", 0, F3_W,   32'h400, 32'h0,        32'h0, 1);
        xt("f_f3011", 0, 3'b011, 32'h10,  32'h0,        32'h0, 1);
        xt("f_sbu",   1, F3_BU,  32'h10,  32'h000000FF, 32'h0, 1);
        xt("lw_after_faults", 0, F3_W, 32'h10, 32'h0, 32'h80ADBEEF, 0);

        // Backpressure: response held, a competing store must be ignored
        @(negedge clk);
        bus.rsp_ready  = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_funct3 = F3_W;
        bus.req_addr   = 32'h10;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        c = 0;
        while (bus.rsp_valid !== 1'b1 && c < 40) begin
            @(posedge clk); #1;
            c++;
        end
        chk("bp_valid", bus.rsp_valid, 1);
        r0 = bus.rsp_rdata;
        e0 = bus.rsp_err;
        chk("bp_rdata", r0, 32'h80ADBEEF);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.req_valid  = 1'b1;
            bus.req_we     = 1'b1;
            bus.req_funct3 = F3_W;
            bus.req_addr   = 32'h10;
            bus.req_wdata  = 32'h55555555;
            @(posedge clk); #1;
            chk($sformatf("bp_hold_valid_%0d", i), bus.rsp_valid, 1);
            chk($sformatf("bp_hold_rdata_%0d", i), bus.rsp_rdata, r0);
            chk($sformatf("bp_hold_err_%0d", i), bus.rsp_err, e0);
            chk($sformatf("bp_hold_ready_%0d", i), bus.req_ready, 0);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", bus.rsp_valid, 0);
        chk("bp_release_ready", bus.req_ready, 1);
        xt("lw_after_bp", 0, F3_W, 32'h10, 32'h0, 32'h80ADBEEF, 0);

        // Reset during WAIT must abort the store
        xt("sw_1111", 1, F3_W, 32'h20, 32'h11111111, 32'h0, 0);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = F3_W;
        bus.req_addr   = 32'h20;
        bus.req_wdata  = 32'h22222222;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("abort_in_wait", bus.req_ready, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_req_ready", bus.req_ready, 1);
        chk("abort_rsp_valid", bus.rsp_valid, 0);
        chk("abort_rsp_rdata", bus.rsp_rdata, 0);
        chk("abort_rsp_err",   bus.rsp_err, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        xt("lw_after_abort", 0, F3_W, 32'h20, 32'h0, 32'h11111111, 0);

        // LATENCY=0 instance, rsp_ready tied high, one request per two cycles
        begin
            logic        we_v [6]   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
            logic [31:0] ad_v [6]   = '{32'h40, 32'h40, 32'h44, 32'h44, 32'h41, 32'h40};
            logic [31:0] wd_v [6]   = '{32'hA5A5A5A5, 0, 32'h01020304, 0, 0, 0};
            logic [31:0] exp_r [6]  = '{32'h0, 32'hA5A5A5A5, 32'h0, 32'h01020304, 32'h0, 32'hA5A5A5A5};
            logic        exp_e [6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                bus0.req_valid  = 1'b1;
                bus0.req_we     = we_v[i];
                bus0.req_funct3 = F3_W;
                bus0.req_addr   = ad_v[i];
                bus0.req_wdata  = wd_v[i];
                @(posedge clk); #1;
                chk($sformatf("l0_valid_%0d", i), bus0.rsp_valid, 1);
                chk($sformatf("l0_rdata_%0d", i), bus0.rsp_rdata, exp_r[i]);
                chk($sformatf("l0_err_%0d", i), bus0.rsp_err, exp_e[i]);
                @(posedge clk); #1;
                chk($sformatf("l0_ready_%0d", i), bus0.req_ready, 1);
            end
            @(negedge clk);
            bus0.req_valid = 1'b0;
        end
`ifdef DMEM_PERF_CNT_EN
        chk("perf_loads",  pl0, 3);
        chk("perf_stores", ps0, 2);
        chk("perf_errs",   pe0, 1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Parametrised data memory with an integrated load/store unit. It replaces the single-cycle word-only data memory.
- Supports RV32 byte, half and word loads and stores, with sign or zero extension.
- Uses a valid/ready request/response handshake and a configurable wait-state latency.
- Flags misaligned, out-of-range and illegal-funct3 accesses.
- Sits between the datapath ALU result/rs2 and the writeback mux; the future multi-cycle core stalls on req_ready/rsp_valid.

Parameters:
- ADDR_W, 32, byte-address width.
- DEPTH, 256, memory size in 32-bit words; must be a power of two, at least 4.
- LATENCY, 1, wait-state cycles inserted before the access (0..15).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  32  load result, already extended; 0 for stores and errors.
- rsp_err  out  1  access fault (misaligned, out of range, or illegal funct3).

Behaviour:
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, FSM=IDLE, wait counter=0.
- Memory array contents are not cleared by rst.
- States:
  - IDLE: req_ready=1. An accept (req_valid&req_ready) registers we, funct3, addr and wdata.
  - WAIT: the counter decrements each cycle.
  - RESP: rsp_valid=1.
- Transitions from IDLE on accept:
  - Fault -> RESP with err=1, rdata=0; no memory write.
  - LATENCY=0 -> access performed in the accept cycle -> RESP.
  - Otherwise -> load counter with LATENCY-1 -> WAIT.
- WAIT -> RESP when the counter is 0; the access is performed in that cycle.
- RESP -> IDLE when rsp_ready=1. rsp_valid and rsp_rdata hold stable until then.
- Latency: rsp_valid rises LATENCY+1 cycles after accept. Maximum throughput is one request per LATENCY+2 cycles.
- Faults:
  - H/HU with addr[0]=1.
  - W with addr[1:0]!=0.
  - Word index addr[ADDR_W-1:2] >= DEPTH.
  - funct3 of 011, 110 or 111.
  - Store with funct3 100 or 101.
- Stores write byte lanes only: SB uses lane addr[1:0]; SH uses lanes {addr[1],0} and {addr[1],1}; SW writes all four lanes.
- Loads:
  - Select the lane(s).
  - B/H sign-extend from bit 7/15.
  - BU/HU zero-extend.
- Requests while not in IDLE are ignored, since req_ready=0.
- rsp_ready asserted before rsp_valid is legal and has no effect.
- rst mid-WAIT aborts the operation; no write occurs, because writes happen only at the access cycle.
- rst in RESP drops the response.

Optional Feature:
- Macro DMEM_PERF_CNT_EN.
- When defined, three 32-bit output ports are added: perf_loads, perf_stores and perf_errs.
  - Each increments on the RESP->IDLE handshake of the corresponding kind.
  - Faulted accesses count only in perf_errs.
  - The counters wrap and reset to 0.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package dmem_pkg holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - the state enum (S_IDLE, S_WAIT, S_RESP);
  - the 4-bit wait-counter width constant.
- One sub-module, dmem_lane_align: combinational store byte-enable/data replication, plus load lane select and extension.

Test Plan:
- LATENCY=2, reset memory by writing zeros: SW 0x10 0xDEADBEEF -> rsp_valid 3 cycles after accept, err=0, rdata=0; then LW 0x10 -> 0xDEADBEEF.
- SB 0x13 0x00000080 -> word 0x80ADBEEF:
  - LB 0x13 -> 0xFFFFFF80;
  - LBU 0x13 -> 0x00000080;
  - LH 0x12 -> 0xFFFF80AD;
  - LHU 0x10 -> 0x0000BEEF.
- Faults, each giving err=1 and rdata=0 with memory unchanged:
  - LW 0x02;
  - SH 0x11;
  - LW at byte address DEPTH*4 = 0x400;
  - funct3=011;
  - store with funct3 100.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid, rdata and err stable, req_ready=0, and a new req_valid is ignored.
- Reset abort: with 0x11111111 already at 0x20, SW 0x20 0x22222222 and assert rst during WAIT -> outputs return to reset values; then LW 0x20 -> 0x11111111.
- LATENCY=0 with rsp_ready tied 1: back-to-back requests complete one per 2 cycles. With DMEM_PERF_CNT_EN, 3 LW + 2 SW + 1 fault gives perf_loads=3, perf_stores=2, perf_errs=1.
